// File: rtl/sprite_render_pipe_if.sv
// Bus between the sprite renderer and its surroundings (dtg, game logic, ROM, colour mux).
// No latency of its own: a plain bundle of wires.
// No flow control: every signal is valid on every clock.
interface sprite_render_pipe_if #(
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 11,
    parameter int COLOR_W = 12
);
    logic               frame_start;
    logic               enable;
    logic               mirror;
    logic [COORD_W-1:0] car_x;
    logic [COORD_W-1:0] car_y;
    logic [COORD_W-1:0] pix_row;
    logic [COORD_W-1:0] pix_col;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_data;
    logic               other_valid;
    logic [COLOR_W-1:0] pix_out;
    logic               pix_valid;
    logic               collide;

    // Environment side: drives the frame controls, pixel scan, ROM data and the other layer.
    modport master (
        output frame_start, enable, mirror, car_x, car_y, pix_row, pix_col,
        output rom_data, other_valid,
        input  rom_addr, pix_out, pix_valid, collide
    );

    // Renderer side.
    modport slave (
        input  frame_start, enable, mirror, car_x, car_y, pix_row, pix_col,
        input  rom_data, other_valid,
        output rom_addr, pix_out, pix_valid, collide
    );
endinterface

// File: rtl/sprite_render_pipe.sv
// Maps the scanned pixel into a sprite ROM; outputs keyed colour, opaque flag and per-frame collision.
// Latency: pix_row/pix_col to pix_out/pix_valid is 3+ROM_LAT clocks; rom_addr is 2 clocks after the pixel.
// No backpressure: one pixel accepted and one produced every clock.
module sprite_render_pipe #(
    parameter int                 SPR_W     = 32,
    parameter int                 SPR_H     = 64,
    parameter int                 ADDR_W    = 11,
    parameter int                 COLOR_W   = 12,
    parameter int                 COORD_W   = 10,
    parameter int                 ROM_LAT   = 1,
    parameter logic [COLOR_W-1:0] KEY_COLOR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    sprite_render_pipe_if.slave   bus
);
    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);
    localparam logic [COORD_W-1:0] W_LIM = COORD_W'(SPR_W);
    localparam logic [COORD_W-1:0] H_LIM = COORD_W'(SPR_H);
    localparam logic [XW-1:0]      X_MAX = XW'(SPR_W - 1);

    // Shadow copies of the per-frame controls
    logic [COORD_W-1:0] sx, sy;
    logic               sen, smir;

    // Stage 1
    logic [COORD_W-1:0] dx_c, dy_c;
    logic [XW-1:0]      s1_dx;
    logic [YW-1:0]      s1_dy;
    logic               s1_inbox, s1_mir;

    // Stage 2 and ROM-latency alignment
    logic [XW-1:0]      xi_c;
    logic [ADDR_W-1:0]  rom_addr_r;
    logic               s2_inbox;
    logic [ROM_LAT-1:0] inbox_dly;

    // Output stage and collision
    logic               hit_c;
    logic [COLOR_W-1:0] pix_out_r;
    logic               pix_valid_r;
    logic               sticky, collide_r;

    assign dx_c  = bus.pix_col - sx;
    assign dy_c  = bus.pix_row - sy;
    // Mirror is carried with the pixel so an in-flight pixel keeps the old frame's flip.
    assign xi_c  = s1_mir ? (X_MAX - s1_dx) : s1_dx;
    assign hit_c = inbox_dly[ROM_LAT-1] && (bus.rom_data != KEY_COLOR);

    // Latch position/enable/mirror once per frame so mid-frame moves cannot tear the sprite.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx   <= '0;
            sy   <= '0;
            sen  <= 1'b0;
            smir <= 1'b0;
        end else if (bus.frame_start) begin
            sx   <= bus.car_x;
            sy   <= bus.car_y;
            sen  <= bus.enable;
            smir <= bus.mirror;
        end
    end

    // Offset into the sprite box; pixels left of/above the box wrap large and fail the unsigned compare.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_dx    <= '0;
            s1_dy    <= '0;
            s1_inbox <= 1'b0;
            s1_mir   <= 1'b0;
        end else begin
            s1_dx    <= dx_c[XW-1:0];
            s1_dy    <= dy_c[YW-1:0];
            s1_inbox <= sen && (dx_c < W_LIM) && (dy_c < H_LIM);
            s1_mir   <= smir;
        end
    end

    // Form the ROM address; it is held when outside the box so the ROM sees no needless toggling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr_r <= '0;
            s2_inbox   <= 1'b0;
        end else begin
            s2_inbox <= s1_inbox;
            if (s1_inbox) begin
                rom_addr_r <= {s1_dy, xi_c};
            end
        end
    end

    // Delay the in-box flag by the ROM latency so it lines up with rom_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inbox_dly <= '0;
        end else begin
            inbox_dly[0] <= s2_inbox;
            for (int i = 1; i < ROM_LAT; i++) begin
                inbox_dly[i] <= inbox_dly[i-1];
            end
        end
    end

    // Apply the transparency key and register the final pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_out_r   <= '0;
            pix_valid_r <= 1'b0;
        end else begin
            pix_out_r   <= hit_c ? bus.rom_data : '0;
            pix_valid_r <= hit_c;
        end
    end

    // Accumulate overlap over a frame and publish it at the next frame_start, including that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky    <= 1'b0;
            collide_r <= 1'b0;
        end else if (bus.frame_start) begin
            collide_r <= sticky | (pix_valid_r && bus.other_valid);
            sticky    <= 1'b0;
        end else if (pix_valid_r && bus.other_valid) begin
            sticky <= 1'b1;
        end
    end

    assign bus.rom_addr  = rom_addr_r;
    assign bus.pix_out   = pix_out_r;
    assign bus.pix_valid = pix_valid_r;
    assign bus.collide   = collide_r;
endmodule

// File: doc/sprite_render_pipe.md
Name: sprite_render_pipe

Overview:
- Parametrised sprite renderer, successor to the fixed 32x64 car blitter.
- Maps the current display pixel (from dtg) into an external sprite ROM and returns the sprite colour, with a transparency key, horizontal mirroring and an opaque-pixel flag.
- Latches sprite position once per frame (tear-free) and reports per-frame collision against another layer.
- Sits between dtg, the game logic and the colour mux; one instance per car.

Parameters:
- SPR_W, 32, sprite width in pixels (power of 2).
- SPR_H, 64, sprite height in pixels (power of 2).
- ADDR_W, 11, ROM address width; must equal log2(SPR_W*SPR_H).
- COLOR_W, 12, pixel colour width.
- COORD_W, 10, pixel and position coordinate width.
- ROM_LAT, 1, ROM read latency in clocks (1..4).
- KEY_COLOR, 12'h000, colour treated as transparent.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- enable  in  1  sprite visible; sampled at frame_start.
- mirror  in  1  horizontal flip; sampled at frame_start.
- car_x  in  COORD_W  sprite left column; sampled at frame_start.
- car_y  in  COORD_W  sprite top row; sampled at frame_start.
- pix_row  in  COORD_W  current dtg row.
- pix_col  in  COORD_W  current dtg column.
- rom_addr  out  ADDR_W  address to sprite ROM.
- rom_data  in  COLOR_W  ROM data, valid ROM_LAT clocks after rom_addr.
- other_valid  in  1  opaque flag of the other layer, aligned to pix_valid.
- pix_out  out  COLOR_W  sprite colour, or 0.
- pix_valid  out  1  current output pixel is opaque sprite.
- collide  out  1  overlap occurred during the previous frame.

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock.
- On reset, all registers clear: shadow pos/enable/mirror=0, rom_addr=0, pix_out=0, pix_valid=0, collide=0, pipeline flags=0.
- Shadow registers: on frame_start, load sx<=car_x, sy<=car_y, sen<=enable, smir<=mirror. Mid-frame changes to these inputs have no effect.
- Stage 1 (registered): dx=pix_col-sx and dy=pix_row-sy, modulo 2^COORD_W.
  - inbox = sen && dx<SPR_W && dy<SPR_H, compared unsigned. Pixels left of or above the sprite wrap to large values and are rejected.
  - Columns past the right screen edge are simply never scanned.
- Stage 2 (registered): rom_addr = {dy[log2 SPR_H-1:0], xi}, where xi = smir ? (SPR_W-1-dx) : dx, truncated to log2 SPR_W bits.
  - When inbox=0, rom_addr holds its previous value.
  - inbox is delayed alongside through a shift register of depth ROM_LAT.
- Output stage (registered): hit = inbox_d && rom_data!=KEY_COLOR.
  - pix_out = hit ? rom_data : 0.
  - pix_valid = hit.
- Latency: pix_row/pix_col to pix_out/pix_valid is exactly 3+ROM_LAT clocks (4 with ROM_LAT=1). The downstream mux delays dtg sync signals by the same amount.
- Collision:
  - Internal sticky bit sets on any cycle with pix_valid && other_valid.
  - On frame_start: collide <= sticky | (pix_valid && other_valid), then sticky clears.
  - collide is therefore stable for a whole frame and reflects the prior frame only.
- frame_start does not flush the pipeline; pixels already in flight finish using the old shadow values.
- Reset mid-frame: outputs go to 0 immediately. Nothing is drawn until the next frame_start with enable=1.
- Coordinates wrap silently; no saturation. If sy+SPR_H exceeds the row range, the sprite is clipped.

Test Plan:
- Reset then frame_start with enable=1, car_x=100, car_y=200; scan (row 200, col 100) -> rom_addr=0 two clocks later; pix_out=rom_data 4 clocks after the pixel, with ROM model data=12'hABC.
- Same setup, scan col 99 and col 132 on row 200 -> pix_valid=0 and pix_out=0 (left wrap and right edge). Col 131, row 263 -> rom_addr=2047.
- mirror=1 latched, pixel (200,100) -> rom_addr=31. Pixel (201,131) -> rom_addr=32.
- Change car_x to 300 mid-frame without frame_start -> rendering stays at col 100. After the next frame_start it moves to col 300.
- ROM returns 12'h000 at an in-box pixel -> pix_valid=0, pix_out=0. other_valid=1 overlapping an opaque pixel in frame N -> collide=1 after frame N+1's frame_start, and 0 after frame N+2's if there is no overlap.
- Assert reset mid-scan while pix_valid=1 -> pix_out, pix_valid and collide go to 0 without a clock edge. ROM_LAT=3 build -> latency measured as 6.
